// File: rtl/operand_stage_pkg.sv
// Shared definitions for the operand stage and the downstream 16-bit shifter:
// shift-code constants, default widths and a reference shift helper.
package operand_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREG_DEF   = 8;
    localparam int SEL_W_DEF  = 3;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [1:0]            shift;
    } operand_t;

    // Single-bit shift as performed by the downstream shifter.
    function automatic logic [DATA_W_DEF-1:0] apply_shift(
        input logic [DATA_W_DEF-1:0] d,
        input logic [1:0]            code
    );
        logic [DATA_W_DEF-1:0] res;
        case (code)
            SH_NONE: res = d;
            SH_LSL:  res = {d[DATA_W_DEF-2:0], 1'b0};
            SH_LSR:  res = {1'b0, d[DATA_W_DEF-1:1]};
            SH_ASR:  res = {d[DATA_W_DEF-1], d[DATA_W_DEF-1:1]};
            default: res = d;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/operand_stage_regfile.sv
// NREG x DATA_W register file: one-hot write decode, combinational read mux.
// Optional write-through forwarding when OPERAND_STAGE_BYPASS_EN is defined.
module operand_stage_regfile
    import operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [SEL_W-1:0]  writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  readnum,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [NREG];
    logic [NREG-1:0]   w_wr_en;
    logic [DATA_W-1:0] w_rd_raw;

    // One-hot write enable per register
    always_comb begin
        w_wr_en = '0;
        for (int i = 0; i < NREG; i++) begin
            w_wr_en[i] = write && (writenum == SEL_W'(i));
        end
    end

    // Register storage, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wr_en[i]) begin
                    r_mem[i] <= data_in;
                end
            end
        end
    end

    assign w_rd_raw = r_mem[readnum];

`ifdef OPERAND_STAGE_BYPASS_EN
    // Forward write data when reading the register being written
    always_comb begin
        if (write && (writenum == readnum)) begin
            rd_data = data_in;
        end else begin
            rd_data = w_rd_raw;
        end
    end
`else
    // Reads always see the pre-write contents
    always_comb begin
        rd_data = w_rd_raw;
    end
`endif

endmodule

// File: rtl/operand_stage.sv
// Operand stage: register file plus operand A/B latches with a valid/ready
// handshake toward the shifter. Optional macro: OPERAND_STAGE_BYPASS_EN.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [SEL_W-1:0]  writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  readnum,
    input  logic              loada,
    input  logic              loadb,
    input  logic [1:0]        shift_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] sh_in,
    output logic [1:0]        shift_out,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] w_rd_data;
    logic              w_stall;
    logic              w_accept;
    logic              w_consume;
    logic              w_in_ready;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_sh_in;
    logic [1:0]        r_shift;
    logic              r_out_valid;

    operand_stage_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .SEL_W  (SEL_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .write    (write),
        .writenum (writenum),
        .data_in  (data_in),
        .readnum  (readnum),
        .rd_data  (w_rd_data)
    );

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_stall    = r_out_valid && !out_ready;
    assign w_accept   = loadb && in_valid && w_in_ready;
    assign w_consume  = r_out_valid && out_ready;

    // Operand B latch and valid flag; a new accept overrides a same-cycle consume
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_in     <= '0;
            r_shift     <= SH_NONE;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_sh_in     <= w_rd_data;
            r_shift     <= shift_in;
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Operand A latch; loads arriving during a stall are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0;
        end else if (loada && !w_stall) begin
            r_a <= w_rd_data;
        end else begin
            r_a <= r_a;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign a_out     = r_a;
    assign sh_in     = r_sh_in;
    assign shift_out = r_shift;
    assign rd_data   = w_rd_data;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: directed vectors push expected operands,
// a negedge monitor pops and compares whenever the DUT hands one downstream.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift_in;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] a_out;
    logic [15:0] sh_in;
    logic [1:0]  shift_out;
    logic [15:0] rd_data;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  shift;
        logic [15:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    operand_stage dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .writenum  (writenum),
        .data_in   (data_in),
        .readnum   (readnum),
        .loada     (loada),
        .loadb     (loadb),
        .shift_in  (shift_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .sh_in     (sh_in),
        .shift_out (shift_out),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Independent model of the downstream single-bit shifter
    function automatic logic [15:0] shifter(input logic [15:0] d, input logic [1:0] c);
        case (c)
            2'b00:   return d;
            2'b01:   return d << 1;
            2'b10:   return d >> 1;
            default: return 16'($signed(d) >>> 1);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] s, input logic [15:0] r);
        exp_t e;
        e.data  = d;
        e.shift = s;
        e.res   = r;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [2:0] n, input logic [15:0] d);
        write    = 1'b1;
        writenum = n;
        data_in  = d;
        tick();
        write    = 1'b0;
    endtask

    // Monitor: each operand handed downstream is checked against the scoreboard
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_operand", 32'(sh_in), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_sh_in", 32'(sh_in), 32'(e.data));
                chk("mon_shift_out", 32'(shift_out), 32'(e.shift));
                chk("mon_shifter_result", 32'(shifter(sh_in, shift_out)), 32'(e.res));
            end
        end
    end

    initial begin
        logic [15:0] coll_exp;
        reset = 1'b1; write = 1'b0; writenum = 3'd0; data_in = 16'd0; readnum = 3'd0;
        loada = 1'b0; loadb = 1'b0; shift_in = 2'b00; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sh_in", 32'(sh_in), 32'd0);
        chk("rst_a_out", 32'(a_out), 32'd0);

        // Write R2=100, capture with LSL
        wr(3'd2, 16'd100);
        readnum = 3'd2; loadb = 1'b1; in_valid = 1'b1; shift_in = 2'b01; out_ready = 1'b1;
        push(16'd100, 2'b01, 16'd200);
        tick();
        loadb = 1'b0; in_valid = 1'b0;
        chk("cap_out_valid", 32'(out_valid), 32'd1);
        chk("cap_sh_in", 32'(sh_in), 32'd100);
        chk("cap_shift_out", 32'(shift_out), 32'd1);
        tick();
        chk("cap_drain", 32'(out_valid), 32'd0);

        // Mid-transfer reset after R3=100 with an operand held
        wr(3'd3, 16'd100);
        readnum = 3'd3; #1;
        chk("r3_read", 32'(rd_data), 32'd100);
        loada = 1'b1; loadb = 1'b1; in_valid = 1'b1; shift_in = 2'b00; out_ready = 1'b0;
        tick();
        loada = 1'b0; loadb = 1'b0; in_valid = 1'b0;
        chk("held_before_reset", 32'(out_valid), 32'd1);
        chk("a_before_reset", 32'(a_out), 32'd100);
        reset = 1'b1;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_r3", 32'(rd_data), 32'd0);
        chk("mrst_a_out", 32'(a_out), 32'd0);
        chk("mrst_sh_in", 32'(sh_in), 32'd0);
        chk("mrst_shift_out", 32'(shift_out), 32'd0);
        tick();
        reset = 1'b0;

        // Backpressure: hold R7 operand, attempt R5 load while stalled
        wr(3'd5, 16'd99);
        wr(3'd7, 16'd11);
        readnum = 3'd7; loada = 1'b1; loadb = 1'b1; in_valid = 1'b1; shift_in = 2'b01; out_ready = 1'b0;
        push(16'd11, 2'b01, 16'd22);
        tick();
        readnum = 3'd5; shift_in = 2'b10;
        tick();
        chk("bp_sh_in", 32'(sh_in), 32'd11);
        chk("bp_shift_out", 32'(shift_out), 32'd1);
        chk("bp_a_out", 32'(a_out), 32'd11);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        loada = 1'b0; loadb = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_drop_valid", 32'(out_valid), 32'd0);

        // Back-to-back: R1=8000 with ASR then LSR
        wr(3'd1, 16'h8000);
        readnum = 3'd1; loadb = 1'b1; in_valid = 1'b1; shift_in = 2'b11;
        push(16'h8000, 2'b11, 16'hC000);
        tick();
        chk("b2b_valid1", 32'(out_valid), 32'd1);
        chk("b2b_shift1", 32'(shift_out), 32'd3);
        shift_in = 2'b10;
        push(16'h8000, 2'b10, 16'h4000);
        tick();
        chk("b2b_valid2", 32'(out_valid), 32'd1);
        chk("b2b_shift2", 32'(shift_out), 32'd2);
        chk("b2b_sh_in", 32'(sh_in), 32'h8000);
        loadb = 1'b0; in_valid = 1'b0;
        tick();
        chk("b2b_drain", 32'(out_valid), 32'd0);

        // Collision: write R4=7 while capturing R4 (old value 1)
`ifdef OPERAND_STAGE_BYPASS_EN
        coll_exp = 16'd7;
`else
        coll_exp = 16'd1;
`endif
        wr(3'd4, 16'd1);
        write = 1'b1; writenum = 3'd4; data_in = 16'd7;
        readnum = 3'd4; loadb = 1'b1; in_valid = 1'b1; shift_in = 2'b00;
        #1;
        chk("coll_rd_data", 32'(rd_data), 32'(coll_exp));
        push(coll_exp, 2'b00, coll_exp);
        tick();
        write = 1'b0; loadb = 1'b0; in_valid = 1'b0;
        chk("coll_sh_in", 32'(sh_in), 32'(coll_exp));
        chk("coll_after_write", 32'(rd_data), 32'd7);
        tick();

        // loada and loadb in the same cycle
        wr(3'd6, 16'd50);
        readnum = 3'd6; loada = 1'b1; loadb = 1'b1; in_valid = 1'b1; shift_in = 2'b01;
        push(16'd50, 2'b01, 16'd100);
        tick();
        loada = 1'b0; loadb = 1'b0; in_valid = 1'b0;
        chk("ab_a_out", 32'(a_out), 32'd50);
        chk("ab_sh_in", 32'(sh_in), 32'd50);
        tick();
        chk("ab_drain", 32'(out_valid), 32'd0);

        // Bounded wait for scoreboard to empty
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            tick();
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
Register-file and operand-latch stage that sits directly upstream of the 16-bit shifter in the datapath.
- Holds eight 16-bit general registers.
- Captures operand A (the future ALU A input) and operand B together with its 2-bit shift code.
- Presents B and the shift code to the shifter through a valid/ready handshake.
- Stalls the stage cleanly when the downstream shifter/ALU path is not ready.

Parameters:
- DATA_W, 16, width of registers and operands
- NREG, 8, number of general registers
- SEL_W, 3, register-select width (log2 NREG)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- write  in  1  register-file write enable
- writenum  in  SEL_W  register-file write address
- data_in  in  DATA_W  register-file write data
- readnum  in  SEL_W  register-file read address (shared by A and B captures)
- loada  in  1  capture R[readnum] into operand A
- loadb  in  1  capture R[readnum] into operand B, plus shift_in
- shift_in  in  2  shift code: 00 none, 01 left, 10 logical right, 11 arithmetic right
- in_valid  in  1  qualifies loadb
- in_ready  out  1  stage can accept a loadb transfer
- out_valid  out  1  sh_in and shift_out hold a valid operand
- out_ready  in  1  downstream consumes the operand
- a_out  out  DATA_W  operand A register
- sh_in  out  DATA_W  operand B register, drives the shifter input
- shift_out  out  2  latched shift code, drives the shifter shift select
- rd_data  out  DATA_W  combinational R[readnum], for debug

Behaviour:
- Reset (asynchronous, active-high) forces:
  - all NREG registers to 0
  - a_out, sh_in and rd_data (via R) to 0
  - shift_out to 00
  - out_valid to 0
- Reset mid-transfer discards any held operand. in_ready is 1 immediately after reset.
- Register file:
  - When write=1, R[writenum] <= data_in at the rising edge.
  - The read is combinational from the current contents.
  - The write is independent of the handshake and is never stalled.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = loadb && in_valid && in_ready. On accept: sh_in <= R[readnum], shift_out <= shift_in, out_valid <= 1. Latency is 1 cycle from accept to out_valid.
  - Consume = out_valid && out_ready. If there is a consume without an accept, out_valid <= 0.
  - Simultaneous accept and consume: the new operand replaces the old one and out_valid stays 1, so full throughput is one operand per cycle.
  - While out_valid=1 and out_ready=0, sh_in and shift_out are held stable and loadb is ignored.
- Operand A:
  - a_out <= R[readnum] when loada=1 and the stage is not stalled (stall = out_valid && !out_ready).
  - loada during a stall is dropped.
  - loada and loadb in the same cycle both capture the same R[readnum].
- Read/write collision (write=1, writenum==readnum, load in the same cycle): the capture gets the OLD register value unless the optional feature is enabled.
- Widths: all data paths are exactly DATA_W with no extension. Select indices cover 0..NREG-1 fully, so no invalid address exists.

Optional Feature:
- Macro: OPERAND_STAGE_BYPASS_EN.
- Defined: on a read/write collision, rd_data and any loada/loadb capture that cycle take data_in (write-through forwarding).
- Undefined: reads return the pre-write register contents. Port list is identical either way.

Decomposition:
- Shared package holds:
  - the shift-code constants SH_NONE=2'b00, SH_LSL=2'b01, SH_LSR=2'b10, SH_ASR=2'b11, shared with the shifter and its bench
  - the DATA_W and SEL_W defaults
- One sub-module, regfile, is natural: an 8x16 array with a one-hot write decoder and a read mux, plus the bypass mux under the macro.
- The handshake and operand latches live in the operand_stage top.

Test Plan:
- Reset check: assert reset mid-run after writing R3=100 → all outputs 0, R3 reads 0, out_valid=0, in_ready=1.
- Write/capture: write R2=100, then readnum=2, loadb, in_valid, shift_in=01, out_ready=1 → next cycle sh_in=100, shift_out=01, out_valid=1, and the downstream shifter yields 200.
- Backpressure: out_ready=0 with out_valid=1; load R5=99 with loadb and loada → sh_in and shift_out unchanged, in_ready=0, a_out unchanged. Release out_ready → out_valid drops next cycle.
- Back-to-back: R1=16'h8000 with shift 11, then R1 reused with shift 10, out_ready held 1 → out_valid stays 1 across both, shift_out sequence 11 then 10, sh_in=16'h8000.
- Collision: write R4=7 while loadb reads R4 (old value 1) → without the macro sh_in=1; with OPERAND_STAGE_BYPASS_EN sh_in=7.
- loada/loadb same cycle: R6=50 → a_out=50 and sh_in=50 after one edge.
